// File: rtl/ntt_core_gf64_col_reorder_pkg.sv
// Shared constants and types for the GF64 NTT core column datapath.
package ntt_core_gf64_common_param_pkg;
  localparam int unsigned R         = 4;
  localparam int unsigned PSI       = 2;
  localparam int unsigned MOD_NTT_W = 14;
  localparam int unsigned L         = PSI * R;
  localparam int unsigned OP_W      = MOD_NTT_W + 2;
  localparam int unsigned CNT_W     = (R > 2) ? $clog2(R) : 1;

  typedef logic [OP_W-1:0] word_t;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } rd_state_e;
endpackage

// File: rtl/ntt_core_gf64_col_reorder_bank.sv
// One R x L reorder bank: row-wise write of an input beat, transposed read per lane group.
module ntt_core_gf64_col_reorder_bank
  import ntt_core_gf64_common_param_pkg::*;
(
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [CNT_W-1:0]        wr_beat,
  input  logic [L-1:0][OP_W-1:0]  wr_data,
  input  logic [CNT_W-1:0]        rd_beat,
  output logic [L-1:0][OP_W-1:0]  rd_data
);

  word_t mem [PSI][R][R];

  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < PSI; p++) begin
      for (int unsigned c = 0; c < R; c++) begin
        for (int unsigned r = 0; r < R; r++) begin
          if (wr_en && wr_beat == CNT_W'(c)) begin
            mem[p][c][r] <= wr_data[p*R + r];
          end
        end
      end
    end
  end

  // Write-through forward lets the first output beat leave on the same edge
  // that stores the last input beat of the block.
  always_comb begin
    rd_data = '0;
    for (int unsigned p = 0; p < PSI; p++) begin
      for (int unsigned c = 0; c < R; c++) begin
        for (int unsigned r = 0; r < R; r++) begin
          if (rd_beat == CNT_W'(r)) begin
            rd_data[p*R + c] = (wr_en && wr_beat == CNT_W'(c)) ? wr_data[p*R + r]
                                                               : mem[p][c][r];
          end
        end
      end
    end
  end

endmodule

// File: rtl/ntt_core_gf64_col_reorder.sv
// Inter-column reorder: ping-pong buffering of R beats, emitted as an R x R transpose per lane group.
module ntt_core_gf64_col_reorder
  import ntt_core_gf64_common_param_pkg::*;
#(
  parameter  int unsigned IN_PIPE  = 1,
  parameter  int unsigned SIDE_W   = 0,
  parameter  logic [1:0]  RST_SIDE = 2'b00,
  localparam int unsigned SIDE_PW  = (SIDE_W > 0) ? SIDE_W : 1
) (
  input  logic                   clk,
  input  logic                   s_rst,
  input  logic [L-1:0][OP_W-1:0] in_data,
  input  logic [L-1:0]           in_avail,
  input  logic [SIDE_PW-1:0]     in_side,
  output logic [L-1:0][OP_W-1:0] out_data,
  output logic [L-1:0]           out_avail,
  output logic [SIDE_PW-1:0]     out_side
);

  localparam logic [SIDE_PW-1:0] SIDE_RST_VAL = {SIDE_PW{RST_SIDE[1]}};
  localparam logic               SIDE_HAS_RST = (RST_SIDE != 2'b00);

  logic [L-1:0][OP_W-1:0] w_data;
  logic                   w_avail;
  logic [SIDE_PW-1:0]     w_side;

  if (IN_PIPE != 0) begin : g_pipe
    logic [L-1:0][OP_W-1:0] pipe_data;
    logic                   pipe_avail;
    logic [SIDE_PW-1:0]     pipe_side;

    always_ff @(posedge clk) begin
      pipe_data <= in_data;
      if (s_rst) pipe_avail <= 1'b0;
      else       pipe_avail <= in_avail[0];
      if (s_rst && SIDE_HAS_RST) pipe_side <= SIDE_RST_VAL;
      else                       pipe_side <= in_side;
    end

    assign w_data  = pipe_data;
    assign w_avail = pipe_avail;
    assign w_side  = pipe_side;
  end else begin : g_nopipe
    assign w_data  = in_data;
    assign w_avail = in_avail[0];
    assign w_side  = in_side;
  end

  logic [CNT_W-1:0] wr_cnt;
  logic             wr_bank;
  logic             wr_done;
  logic             side_we;
  logic [1:0]       bank_full;
  logic [1:0]       set_vec;
  logic [1:0]       clr_vec;
  logic [1:0]       full_eff;

  assign wr_done = w_avail && (wr_cnt == CNT_W'(R - 1));
  assign side_we = w_avail && (wr_cnt == '0);

  always_comb begin
    set_vec          = '0;
    set_vec[wr_bank] = wr_done;
  end

  // A block completing this cycle is visible to the read FSM immediately.
  assign full_eff = bank_full | set_vec;

  always_ff @(posedge clk) begin
    if (s_rst) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (w_avail) begin
      if (wr_done) begin
        wr_cnt  <= '0;
        wr_bank <= ~wr_bank;
      end else begin
        wr_cnt  <= wr_cnt + 1'b1;
      end
    end
  end

  rd_state_e        state, state_n;
  logic [CNT_W-1:0] rd_cnt, rd_cnt_n;
  logic             rd_bank, rd_bank_n;

  always_comb begin
    state_n   = state;
    rd_cnt_n  = rd_cnt;
    rd_bank_n = rd_bank;
    clr_vec   = '0;
    case (state)
      IDLE: begin
        if (full_eff[rd_bank]) begin
          state_n  = EMIT;
          rd_cnt_n = '0;
        end
      end
      EMIT: begin
        if (rd_cnt == CNT_W'(R - 1)) begin
          clr_vec[rd_bank] = 1'b1;
          rd_bank_n        = ~rd_bank;
          rd_cnt_n         = '0;
          state_n          = full_eff[rd_bank_n] ? EMIT : IDLE;
        end else begin
          rd_cnt_n = rd_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (s_rst) begin
      state     <= IDLE;
      rd_cnt    <= '0;
      rd_bank   <= 1'b0;
      bank_full <= '0;
    end else begin
      state     <= state_n;
      rd_cnt    <= rd_cnt_n;
      rd_bank   <= rd_bank_n;
      bank_full <= (bank_full & ~clr_vec) | set_vec;
    end
  end

  logic [L-1:0][OP_W-1:0] rd_data0, rd_data1;

  ntt_core_gf64_col_reorder_bank u_bank0 (
    .clk     (clk),
    .wr_en   (w_avail && !wr_bank),
    .wr_beat (wr_cnt),
    .wr_data (w_data),
    .rd_beat (rd_cnt_n),
    .rd_data (rd_data0)
  );

  ntt_core_gf64_col_reorder_bank u_bank1 (
    .clk     (clk),
    .wr_en   (w_avail && wr_bank),
    .wr_beat (wr_cnt),
    .wr_data (w_data),
    .rd_beat (rd_cnt_n),
    .rd_data (rd_data1)
  );

  // Registered outputs are loaded from the next-state view so the state
  // register always describes the beat currently on out_data.
  always_ff @(posedge clk) begin
    if (s_rst) out_avail <= '0;
    else       out_avail <= {L{state_n == EMIT}};
    if (state_n == EMIT) out_data <= rd_bank_n ? rd_data1 : rd_data0;
  end

  logic [SIDE_PW-1:0] side_q [2];
  logic [SIDE_PW-1:0] side_rd;

  assign side_rd = (side_we && wr_bank == rd_bank_n) ? w_side : side_q[rd_bank_n];

  always_ff @(posedge clk) begin
    if (s_rst && SIDE_HAS_RST) begin
      side_q[0] <= SIDE_RST_VAL;
      side_q[1] <= SIDE_RST_VAL;
      out_side  <= SIDE_RST_VAL;
    end else begin
      if (side_we) side_q[wr_bank] <= w_side;
      out_side <= side_rd;
    end
  end

`ifndef SYNTHESIS
  a_lane_consistent: assert property (@(posedge clk) disable iff (s_rst)
    (in_avail == '0) || (in_avail == '1));
  a_no_overflow: assert property (@(posedge clk) disable iff (s_rst)
    !(wr_done && bank_full[wr_bank]));
  a_avail_known: assert property (@(posedge clk) disable iff (s_rst)
    !$isunknown(out_avail));
`endif

endmodule

// File: tb/tb_ntt_core_gf64_col_reorder.sv
// Directed bench for the column reorder stage: one unpiped and one piped instance fed the same stream.
module tb_ntt_core_gf64_col_reorder;
  import ntt_core_gf64_common_param_pkg::*;

  typedef logic [L-1:0][OP_W-1:0] vec_t;

  typedef struct {
    int         cyc;
    logic [L-1:0] avail;
    vec_t       data;
    logic [3:0] side;
  } ent_t;

  logic         clk = 1'b0;
  logic         s_rst = 1'b1;
  vec_t         in_data = '0;
  logic [L-1:0] in_avail = '0;
  logic [3:0]   in_side = '0;

  vec_t         out_data0, out_data1;
  logic [L-1:0] out_avail0, out_avail1;
  logic [3:0]   out_side0, out_side1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  ent_t log0[$];
  ent_t log1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ntt_core_gf64_col_reorder #(.IN_PIPE(0), .SIDE_W(4), .RST_SIDE(2'b00)) dut0 (
    .clk(clk), .s_rst(s_rst), .in_data(in_data), .in_avail(in_avail), .in_side(in_side),
    .out_data(out_data0), .out_avail(out_avail0), .out_side(out_side0)
  );

  ntt_core_gf64_col_reorder #(.IN_PIPE(1), .SIDE_W(4), .RST_SIDE(2'b10)) dut1 (
    .clk(clk), .s_rst(s_rst), .in_data(in_data), .in_avail(in_avail), .in_side(in_side),
    .out_data(out_data1), .out_avail(out_avail1), .out_side(out_side1)
  );

  always @(negedge clk) begin
    if (out_avail0 !== '0) log0.push_back('{cyc, out_avail0, out_data0, out_side0});
    if (out_avail1 !== '0) log1.push_back('{cyc, out_avail1, out_data1, out_side1});
  end

  // Input beat c of block b: lane p*R+r carries 1000b + 100c + 10p + r.
  function automatic vec_t in_vec(int b, int c);
    vec_t v;
    for (int unsigned p = 0; p < PSI; p++)
      for (int unsigned r = 0; r < R; r++)
        v[p*R + r] = OP_W'(1000*b + 100*c + 10*int'(p) + int'(r));
    return v;
  endfunction

  // Output beat r of block b: lane p*R+c carries the same formula.
  function automatic vec_t exp_out(int b, int r);
    vec_t v;
    for (int unsigned p = 0; p < PSI; p++)
      for (int unsigned c = 0; c < R; c++)
        v[p*R + c] = OP_W'(1000*b + 100*int'(c) + 10*int'(p) + r);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(int b, int c, logic [3:0] side);
    in_data  = in_vec(b, c);
    in_avail = '1;
    in_side  = (c == 0) ? side : 4'hA;
    tick();
    in_avail = '0;
    in_side  = 4'hA;
  endtask

  task automatic idle(int n);
    in_avail = '0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    s_rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (out_avail0 !== '0) begin
      errors++; $display("FAIL reset_avail0: got %b want 0", out_avail0);
    end
    checks++;
    if (out_avail1 !== '0) begin
      errors++; $display("FAIL reset_avail1: got %b want 0", out_avail1);
    end
    checks++;
    if (out_side1 !== 4'hF) begin
      errors++; $display("FAIL reset_side1: got %h want f", out_side1);
    end
    s_rst = 1'b0;
    idle(4);
    checks++;
    if (out_avail0 !== '0) begin
      errors++; $display("FAIL idle_avail0: got %b want 0", out_avail0);
    end
    checks++;
    if (out_side1 !== 4'hF) begin
      errors++; $display("FAIL idle_side1: got %h want f", out_side1);
    end
  endtask

  task automatic test_single_block();
    int t0;
    logic [OP_W-1:0] lane5;
    log0.delete(); log1.delete();
    t0 = cyc;
    for (int c = 0; c < 4; c++) drive_beat(0, c, 4'h5);
    idle(8);
    checks++;
    if (log0.size() != 4) begin
      errors++; $display("FAIL single_count: got %0d want 4", log0.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= log0.size()) begin
        errors++; $display("FAIL single_beat%0d: missing, want cyc %0d", i, t0 + 4 + i);
      end else if (log0[i].cyc !== t0 + 4 + i || log0[i].data !== exp_out(0, i) ||
                   log0[i].avail !== 8'hFF || log0[i].side !== 4'h5) begin
        errors++;
        $display("FAIL single_beat%0d: got cyc %0d avail %h data %h side %h want cyc %0d avail ff data %h side 5",
                 i, log0[i].cyc, log0[i].avail, log0[i].data, log0[i].side, t0 + 4 + i, exp_out(0, i));
      end
    end
    lane5 = (log0.size() > 2) ? log0[2].data[5] : 'x;
    checks++;
    if (lane5 !== OP_W'(112)) begin
      errors++; $display("FAIL single_b2_lane5: got %0d want 112", lane5);
    end
  endtask

  task automatic test_gapped();
    int t0;
    log0.delete(); log1.delete();
    t0 = cyc;
    drive_beat(1, 0, 4'h6);
    idle(2);
    drive_beat(1, 1, 4'h6);
    drive_beat(1, 2, 4'h6);
    idle(5);
    drive_beat(1, 3, 4'h6);
    idle(8);
    checks++;
    if (log0.size() != 4) begin
      errors++; $display("FAIL gapped_count: got %0d want 4", log0.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= log0.size()) begin
        errors++; $display("FAIL gapped_beat%0d: missing, want cyc %0d", i, t0 + 11 + i);
      end else if (log0[i].cyc !== t0 + 11 + i || log0[i].data !== exp_out(1, i) ||
                   log0[i].side !== 4'h6) begin
        errors++;
        $display("FAIL gapped_beat%0d: got cyc %0d data %h side %h want cyc %0d data %h side 6",
                 i, log0[i].cyc, log0[i].data, log0[i].side, t0 + 11 + i, exp_out(1, i));
      end
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    log0.delete(); log1.delete();
    t0 = cyc;
    for (int b = 0; b < 3; b++)
      for (int c = 0; c < 4; c++) drive_beat(2 + b, c, 4'(b + 1));
    idle(8);
    checks++;
    if (log0.size() != 12) begin
      errors++; $display("FAIL b2b_count: got %0d want 12", log0.size());
    end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (i >= log0.size()) begin
        errors++; $display("FAIL b2b_beat%0d: missing, want cyc %0d", i, t0 + 4 + i);
      end else if (log0[i].cyc !== t0 + 4 + i || log0[i].data !== exp_out(2 + i / 4, i % 4) ||
                   log0[i].side !== 4'(i / 4 + 1)) begin
        errors++;
        $display("FAIL b2b_beat%0d: got cyc %0d data %h side %h want cyc %0d data %h side %0d",
                 i, log0[i].cyc, log0[i].data, log0[i].side, t0 + 4 + i,
                 exp_out(2 + i / 4, i % 4), i / 4 + 1);
      end
    end
  endtask

  task automatic test_in_pipe();
    int t0;
    log0.delete(); log1.delete();
    t0 = cyc;
    for (int c = 0; c < 4; c++) drive_beat(8, c, 4'hC);
    idle(9);
    checks++;
    if (log1.size() != 4) begin
      errors++; $display("FAIL pipe_count: got %0d want 4", log1.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= log1.size()) begin
        errors++; $display("FAIL pipe_beat%0d: missing, want cyc %0d", i, t0 + 5 + i);
      end else if (log1[i].cyc !== t0 + 5 + i || log1[i].data !== exp_out(8, i) ||
                   log1[i].side !== 4'hC) begin
        errors++;
        $display("FAIL pipe_beat%0d: got cyc %0d data %h side %h want cyc %0d data %h side c",
                 i, log1[i].cyc, log1[i].data, log1[i].side, t0 + 5 + i, exp_out(8, i));
      end
    end
  endtask

  task automatic test_reset_mid_op();
    int t0;
    log0.delete(); log1.delete();
    t0 = cyc;
    for (int c = 0; c < 4; c++) drive_beat(5, c, 4'h3);
    drive_beat(6, 0, 4'h4);
    drive_beat(6, 1, 4'h4);
    in_data  = in_vec(6, 2);
    in_avail = '1;
    s_rst    = 1'b1;
    tick();
    s_rst    = 1'b0;
    in_avail = '0;
    idle(6);
    checks++;
    if (log0.size() != 3) begin
      errors++; $display("FAIL rst_mid_count0: got %0d want 3", log0.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= log0.size()) begin
        errors++; $display("FAIL rst_mid_beat%0d: missing, want cyc %0d", i, t0 + 4 + i);
      end else if (log0[i].cyc !== t0 + 4 + i || log0[i].data !== exp_out(5, i)) begin
        errors++;
        $display("FAIL rst_mid_beat%0d: got cyc %0d data %h want cyc %0d data %h",
                 i, log0[i].cyc, log0[i].data, t0 + 4 + i, exp_out(5, i));
      end
    end
    checks++;
    if (log1.size() != 2) begin
      errors++; $display("FAIL rst_mid_count1: got %0d want 2", log1.size());
    end
    checks++;
    if (out_side1 !== 4'hF) begin
      errors++; $display("FAIL rst_mid_side1: got %h want f", out_side1);
    end

    log0.delete(); log1.delete();
    t0 = cyc;
    for (int c = 0; c < 4; c++) drive_beat(7, c, 4'h9);
    idle(8);
    checks++;
    if (log0.size() != 4 || log1.size() != 4) begin
      errors++; $display("FAIL post_rst_count: got %0d/%0d want 4/4", log0.size(), log1.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= log0.size()) begin
        errors++; $display("FAIL post_rst_beat%0d: missing, want cyc %0d", i, t0 + 4 + i);
      end else if (log0[i].cyc !== t0 + 4 + i || log0[i].data !== exp_out(7, i) ||
                   log0[i].side !== 4'h9) begin
        errors++;
        $display("FAIL post_rst_beat%0d: got cyc %0d data %h side %h want cyc %0d data %h side 9",
                 i, log0[i].cyc, log0[i].data, log0[i].side, t0 + 4 + i, exp_out(7, i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_gapped();
    test_back_to_back();
    test_in_pipe();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
